// File: rtl/axi4_lite_cmd_mst_if.sv
// Command/response stream plus AXI4-Lite bus bundle for axi4_lite_cmd_mst.
// The master modport is the command master's view; slave is its mirror.
interface axi4_lite_cmd_mst_if #(
    parameter int unsigned ADDR_BIT_WIDTH = 4,
    parameter int unsigned DATA_BIT_WIDTH = 32,
    parameter int unsigned LAT_BIT_WIDTH  = 16
);
    localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

    // Command stream
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_is_wr;
    logic [ADDR_BIT_WIDTH-1:0] cmd_addr;
    logic [DATA_BIT_WIDTH-1:0] cmd_wdata;
    logic [STRB_BIT_WIDTH-1:0] cmd_wstrb;

    // Response stream
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_is_wr;
    logic [DATA_BIT_WIDTH-1:0] rsp_rdata;
    logic [1:0]                rsp_resp;
    logic [LAT_BIT_WIDTH-1:0]  rsp_lat;

    // AXI4-Lite write channels
    logic [ADDR_BIT_WIDTH-1:0] awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_BIT_WIDTH-1:0] wdata;
    logic [STRB_BIT_WIDTH-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    // AXI4-Lite read channels
    logic [ADDR_BIT_WIDTH-1:0] araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_BIT_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        input  cmd_valid, cmd_is_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_is_wr, rsp_rdata, rsp_resp, rsp_lat,
        input  rsp_ready,
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        output cmd_valid, cmd_is_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_is_wr, rsp_rdata, rsp_resp, rsp_lat,
        output rsp_ready,
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response (resp, read data, saturating latency) back. All outputs registered.
module axi4_lite_cmd_mst #(
    parameter int unsigned ADDR_BIT_WIDTH = 4,
    parameter int unsigned DATA_BIT_WIDTH = 32,
    parameter int unsigned LAT_BIT_WIDTH  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    axi4_lite_cmd_mst_if.master bus
);
    localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRdAddr,
        StRdData,
        StRsp
    } state_e;

    state_e                    state_q;
    logic                      cmd_ready_q;
    logic                      is_wr_q;
    logic [ADDR_BIT_WIDTH-1:0] addr_q;
    logic [DATA_BIT_WIDTH-1:0] wdata_q;
    logic [STRB_BIT_WIDTH-1:0] wstrb_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      bready_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic                      rsp_valid_q;
    logic [DATA_BIT_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]                rsp_resp_q;
    logic [LAT_BIT_WIDTH-1:0]  lat_q;

    logic                      aw_hs;
    logic                      w_hs;
    logic                      aw_done;
    logic                      w_done;
    logic [LAT_BIT_WIDTH-1:0]  lat_inc;

    assign aw_hs   = awvalid_q & bus.awready;
    assign w_hs    = wvalid_q & bus.wready;
    // A channel is finished once its valid has dropped or it handshakes now.
    assign aw_done = ~awvalid_q | aw_hs;
    assign w_done  = ~wvalid_q | w_hs;
    assign lat_inc = (lat_q == '1) ? lat_q : lat_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            lat_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        is_wr_q     <= bus.cmd_is_wr;
                        addr_q      <= bus.cmd_addr;
                        wdata_q     <= bus.cmd_wdata;
                        wstrb_q     <= bus.cmd_wstrb;
                        lat_q       <= '0;
                        if (bus.cmd_is_wr) begin
                            state_q   <= StWr;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= StRdAddr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    lat_q <= lat_inc;
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state_q  <= StWrResp;
                        bready_q <= 1'b1;
                    end
                end
                StWrResp: begin
                    lat_q <= lat_inc;
                    if (bus.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= bus.bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StRdAddr: begin
                    lat_q <= lat_inc;
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    lat_q <= lat_inc;
                    if (bus.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= bus.rresp;
                        rsp_rdata_q <= bus.rdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    // Latency is frozen here; it is the reported value.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_is_wr = is_wr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_resp  = rsp_resp_q;
    assign bus.rsp_lat   = lat_q;

    assign bus.awaddr  = addr_q;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = awvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;

    assign bus.araddr  = addr_q;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;
endmodule
